// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, shared sample tick, saturating debounce
// counter and rising-edge pulse per channel. Define BUTTON_TOGGLE_EN to add the toggle output.
module button_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef BUTTON_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle
`endif
);

  localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_TOP   = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_q;
  logic [SW-1:0]    sample_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // With SAMPLE_CNT_MAX = 1 the counter sits at 0 and tick is permanently high.
  assign tick = (sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) sample_cnt <= '0;
    else             sample_cnt <= sample_cnt + SW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt;

    // Any low sample discards progress, so a bounce restarts qualification.
    always_ff @(posedge clk) begin
      if (rst || !sync2[i])                cnt <= '0;
      else if (tick && (cnt != PULSE_TOP)) cnt <= cnt + CW'(1);
    end

    assign stable[i] = (cnt == PULSE_TOP);
  end

  always_ff @(posedge clk) begin
    if (rst) stable_q <= '0;
    else     stable_q <= stable;
  end

  assign out = stable & ~stable_q;

`ifdef BUTTON_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (rst) toggle <= '0;
    else     toggle <= toggle ^ out;
  end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
// Pulse cycles are counted from the first rising edge after the input change.
module tb_button_conditioner;

  localparam int W   = 2;
  localparam int LO  = 11;  // earliest pulse cycle: 2 sync + first tick at cycle 3 + 2*4
  localparam int HI  = 14;  // latest: first tick can land up to 3 cycles later

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_r;
  logic [W-1:0] out;
`ifdef BUTTON_TOGGLE_EN
  logic [W-1:0] toggle;
`endif

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  button_conditioner #(
    .WIDTH(W),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in_r),
    .out(out)
`ifdef BUTTON_TOGGLE_EN
    ,
    .toggle(toggle)
`endif
  );

  typedef struct {
    logic [W-1:0] pat;
    int           hold;
    int           exp0;
    int           exp1;
  } vec_t;

  vec_t vecs[7];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Drive pat for n cycles; count high samples of out and record first pulse cycle.
  task automatic run_pat(input logic [W-1:0] pat, input int n,
                         output int c0, output int c1, output int f0, output int f1);
    c0 = 0; c1 = 0; f0 = 0; f1 = 0;
    in_r = pat;
    for (int k = 1; k <= n; k++) begin
      cyc();
      if (out[0]) begin c0++; if (f0 == 0) f0 = k; end
      if (out[1]) begin c1++; if (f1 == 0) f1 = k; end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc();
      chk("out_in_reset", int'(out), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int c0, c1, f0, f1, r0, r1, rf0, rf1;
    int k;
    int pulse_seen;

    vecs[0] = '{pat: 2'b00, hold: 50, exp0: 0, exp1: 0};
    vecs[1] = '{pat: 2'b01, hold: 40, exp0: 1, exp1: 0};
    vecs[2] = '{pat: 2'b01, hold: 5,  exp0: 0, exp1: 0};
    vecs[3] = '{pat: 2'b10, hold: 40, exp0: 0, exp1: 1};
    vecs[4] = '{pat: 2'b11, hold: 40, exp0: 1, exp1: 1};
    vecs[5] = '{pat: 2'b10, hold: 8,  exp0: 0, exp1: 0};
    vecs[6] = '{pat: 2'b01, hold: 20, exp0: 1, exp1: 0};

    rst  = 1'b1;
    in_r = '0;
    @(negedge clk);
    do_reset(3);

`ifdef BUTTON_TOGGLE_EN
    k = 0;
    for (int j = 0; j < 50; j++) begin
      cyc();
      if (toggle != '0) k++;
    end
    chk("toggle_idle_samples", k, 0);
`endif

    foreach (vecs[v]) begin
      run_pat(vecs[v].pat, vecs[v].hold, c0, c1, f0, f1);
      run_pat(2'b00, 12, r0, r1, rf0, rf1);
      chk($sformatf("vec%0d_pulses_ch0", v), c0 + r0, vecs[v].exp0);
      chk($sformatf("vec%0d_pulses_ch1", v), c1 + r1, vecs[v].exp1);
      if (vecs[v].exp0 == 1) chk_win($sformatf("vec%0d_latency_ch0", v), f0, LO, HI);
      if (vecs[v].exp1 == 1) chk_win($sformatf("vec%0d_latency_ch1", v), f1, LO, HI);
      if (vecs[v].exp0 == 1 && vecs[v].exp1 == 1)
        chk($sformatf("vec%0d_simultaneous", v), f1, f0);
    end

    // Bounce 1,0,1,0 every 3 cycles, then steady press.
    k = 0;
    for (int b = 0; b < 4; b++) begin
      run_pat((b % 2 == 0) ? 2'b01 : 2'b00, 3, c0, c1, f0, f1);
      k += c0 + c1;
    end
    chk("bounce_no_pulse", k, 0);
    run_pat(2'b01, 40, c0, c1, f0, f1);
    run_pat(2'b00, 12, r0, r1, rf0, rf1);
    chk("bounce_steady_pulses", c0 + r0, 1);
    chk_win("bounce_steady_latency", f0, LO, HI);
    chk("bounce_ch1_quiet", c1 + r1, 0);

    // Reset right after the first pulse of a held button.
    in_r = 2'b01;
    pulse_seen = 0;
    for (int j = 0; j < 30 && pulse_seen == 0; j++) begin
      cyc();
      if (out[0]) pulse_seen = 1;
    end
    chk("midrst_first_pulse_seen", pulse_seen, 1);
    do_reset(2);
`ifdef BUTTON_TOGGLE_EN
    chk("midrst_toggle_cleared", int'(toggle), 0);
`endif
    run_pat(2'b01, 30, c0, c1, f0, f1);
    chk("midrst_repulse_count", c0, 1);
    chk("midrst_repulse_cycle", f0, 12);
    run_pat(2'b00, 12, r0, r1, rf0, rf1);
    chk("midrst_release_quiet", r0 + r1, 0);

`ifdef BUTTON_TOGGLE_EN
    begin
      int exp_t[3];
      int prev;
      exp_t[0] = 1; exp_t[1] = 0; exp_t[2] = 1;
      do_reset(2);
      prev = 0;
      for (int p = 0; p < 3; p++) begin
        in_r = 2'b01;
        pulse_seen = 0;
        for (int j = 0; j < 30 && pulse_seen == 0; j++) begin
          cyc();
          if (out[0]) pulse_seen = 1;
        end
        chk($sformatf("tog%0d_pulse_seen", p), pulse_seen, 1);
        chk($sformatf("tog%0d_before", p), int'(toggle[0]), prev);
        cyc();
        chk($sformatf("tog%0d_after", p), int'(toggle[0]), exp_t[p]);
        prev = exp_t[p];
        run_pat(2'b01, 10, c0, c1, f0, f1);
        run_pat(2'b00, 12, r0, r1, rf0, rf1);
        chk($sformatf("tog%0d_hold", p), int'(toggle[0]), exp_t[p]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
